// File: rtl/mdu.sv
// mdu - iterative RV32M multiply/divide unit.
//
// Takes both register-file read values and a destination register, and
// returns a result, the latched destination and a one-cycle write strobe for
// the register file's write port. It has one shared 64-bit accumulator that
// retires one bit per cycle: shift-add for multiply, restoring
// shift-subtract for divide.
//
// Ports
//   clk_i      : clock, rising edge
//   reset      : synchronous, active-high reset
//   start_i    : request, accepted only while busy_o=0
//   op_i       : 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   a_i, b_i   : rs1 / rs2 operands (sampled only on the accepting edge)
//   rd_addr_i  : destination register
//   busy_o     : high while the unit is not idle
//   valid_o    : one-cycle result strobe (rf we3_i)
//   result_o   : result (rf wd3_i), holds until the next accepted start
//   rd_addr_o  : latched destination (rf a3_i)
module mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [4:0]      rd_addr_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    state_t            state_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [5:0]        cnt_q;
    logic              neg_q;     // result sign to apply in FIX
    logic [XLEN-1:0]   bmag_q;    // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q;     // {hi/rem, lo/quot}
    logic [XLEN-1:0]   result_q;
    logic              valid_q;

    // ---------------- request decode (IDLE) ----------------
    logic            a_sgn, b_sgn, neg_d, special_d;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        a_sgn = a_i[XLEN-1] & ((op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                               (op_i == OP_DIV)  || (op_i == OP_REM));
        b_sgn = b_i[XLEN-1] & ((op_i == OP_MULH) || (op_i == OP_DIV) ||
                               (op_i == OP_REM));
        a_mag = a_sgn ? -a_i : a_i;
        b_mag = b_sgn ? -b_i : b_i;
        // Remainder takes the dividend's sign; everything else the xor.
        neg_d = (op_i == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);

        special_d   = 1'b0;
        special_res = '0;
        if (op_i[2] && (b_i == '0)) begin
            special_d   = 1'b1;
            special_res = op_i[1] ? a_i : '1;           // REM*: dividend, DIV*: all ones
        end else if (((op_i == OP_DIV) || (op_i == OP_REM)) &&
                     (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1)) begin
            special_d   = 1'b1;
            special_res = op_i[1] ? '0 : a_i;           // REM: 0, DIV: most-negative
        end
    end

    // ---------------- one iteration step (CALC) ----------------
    logic [XLEN:0]     mul_sum, rem_sh;
    logic              rem_ge;
    logic [2*XLEN-1:0] acc_d;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the LSB of the
        // multiplier (low half) is set, then shift right with the carry in.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, bmag_q};
        // Divide: the shifted partial remainder is one bit wider than XLEN.
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        rem_ge  = rem_sh >= {1'b0, bmag_q};
        acc_d   = '0;
        if (!op_q[2]) begin
            acc_d = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                             : {1'b0, acc_q[2*XLEN-1:1]};
        end else begin
            // rem_sh < 2*divisor, so the difference always fits in XLEN bits.
            acc_d = rem_ge ? {rem_sh[XLEN-1:0] - bmag_q, acc_q[XLEN-2:0], 1'b1}
                           : {acc_q[2*XLEN-2:0], 1'b0};
        end
    end

    // ---------------- sign fix and output select (FIX) ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, result_d;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       result_d = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result_d = quot_fix;
            default:                      result_d = rem_fix;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            bmag_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (start_i) begin
                        op_q   <= op_i;
                        rd_q   <= rd_addr_i;
                        neg_q  <= neg_d;
                        bmag_q <= b_mag;
                        acc_q  <= {{XLEN{1'b0}}, a_mag};
                        cnt_q  <= '0;
                        if (special_d) begin
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= FIX;
                end
                FIX: begin
                    result_q <= result_d;
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end
                default: begin  // DONE
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign rd_addr_o = rd_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu - directed bench for mdu with an in-bench reference model.
// Inputs change 2 time units after a rising edge; outputs are checked on the
// falling edge by a single monitor that also decides which starts the unit
// accepts, from an operation-level timing model.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset, start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic [4:0]  rd_addr_i;
    logic        busy_o, valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    mdu dut (
        .clk_i     (clk),
        .reset     (reset),
        .start_i   (start_i),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .rd_addr_i (rd_addr_i),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .result_o  (result_o),
        .rd_addr_o (rd_addr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 3'd4 && b == 32'd0) return 1'b1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] da, db, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        da = a;
        db = b;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = da / db; return r;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                r = da % db; return r;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          m_free_at = 0;   // first falling-edge cycle at which the unit is idle
    logic [31:0] m_result = 0;
    logic [4:0]  m_rd = 0;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            m_free_at = cyc + 1;
            m_result  = 0;
            m_rd      = 0;
        end else begin
            chk("busy", {31'd0, busy_o}, {31'd0, cyc < m_free_at});
            if (valid_o) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", {31'd0, valid_o}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", result_o, e.res);
                    chk("rd_addr", {27'd0, rd_addr_o}, {27'd0, e.rd});
                    chk("valid_cycle", cyc, e.due);
                    m_result = e.res;
                end
            end else if (q.size() > 0 && cyc >= q[0].due) begin
                chk("valid_missing", {31'd0, valid_o}, 32'd1);
                m_result = q[0].res;
                void'(q.pop_front());
            end
            if (cyc >= m_free_at) begin
                chk("idle_result", result_o, m_result);
                chk("idle_rd", {27'd0, rd_addr_o}, {27'd0, m_rd});
            end
            if (start_i && cyc >= m_free_at) begin
                logic spc;
                spc = is_special(op_i, a_i, b_i);
                q.push_back('{model(op_i, a_i, b_i), rd_addr_i, cyc + 1 + (spc ? 0 : 33)});
                m_free_at = cyc + (spc ? 2 : 35);
                m_rd      = rd_addr_i;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (cyc < m_free_at) begin
            tick();
            if (++k > 200) begin
                chk("idle_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    // Issue one op; exp is the hand-computed result, pinning the model.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
        wait_idle();
        chk("model_pin", model(op, a, b), exp);
        start_i = 1; op_i = op; a_i = a; b_i = b; rd_addr_i = rd;
        tick();
        start_i = 0;
        a_i = $urandom; b_i = $urandom; rd_addr_i = 5'($urandom);
    endtask

    initial begin
        reset = 1; start_i = 0; op_i = 0; a_i = 0; b_i = 0; rd_addr_i = 0;
        tick(); tick();
        reset = 0;
        tick();
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_rd", {27'd0, rd_addr_o}, 32'd0);

        do_op(3'd0, 32'd7, 32'd6, 5'd5, 32'h0000_002A);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'h4000_0000);
        do_op(3'd0, 32'h8000_0000, 32'd2, 5'd10, 32'h0000_0000);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFD);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFF);
        do_op(3'd5, 32'd100, 32'd7, 5'd13, 32'd14);
        do_op(3'd7, 32'd100, 32'd7, 5'd0, 32'd2);
        do_op(3'd5, 32'd123, 32'd0, 5'd14, 32'hFFFF_FFFF);
        do_op(3'd6, 32'd123, 32'd0, 5'd15, 32'd123);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000);
        do_op(3'd4, 32'h8000_0000, 32'd1, 5'd18, 32'h8000_0000);
        do_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd19, 32'd1);

        // Reset in the middle of CALC: the pending op must vanish.
        do_op(3'd0, 32'd12345, 32'd678, 5'd3, 32'd8369910);
        repeat (10) tick();
        reset = 1;
        tick();
        reset = 0;
        chk("midreset_busy", {31'd0, busy_o}, 32'd0);
        chk("midreset_result", result_o, 32'd0);
        do_op(3'd0, 32'd3, 32'd3, 5'd9, 32'd9);

        // Start coincident with reset is discarded.
        wait_idle();
        reset = 1; start_i = 1; op_i = 3'd5; a_i = 32'd10; b_i = 32'd2; rd_addr_i = 5'd1;
        tick();
        reset = 0; start_i = 0;
        tick();
        chk("reset_start_busy", {31'd0, busy_o}, 32'd0);

        // Reset while DONE: the strobe must drop after the reset edge.
        do_op(3'd5, 32'd100, 32'd7, 5'd4, 32'd14);
        begin
            int k = 0;
            while (!valid_o && k < 60) begin tick(); k++; end
            chk("done_reached", {31'd0, valid_o}, 32'd1);
        end
        reset = 1;
        tick();
        reset = 0;
        chk("done_reset_valid", {31'd0, valid_o}, 32'd0);
        chk("done_reset_result", result_o, 32'd0);

        // start_i held high with operands changing every cycle.
        wait_idle();
        start_i = 1;
        for (int i = 0; i < 200; i++) begin
            op_i = 3'($urandom);
            a_i = $urandom;
            b_i = (i % 7 == 0) ? 32'd0 : $urandom;
            rd_addr_i = 5'($urandom);
            tick();
        end
        start_i = 0;
        wait_idle();
        repeat (3) tick();
        chk("queue_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
